// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART blocks: parity modes, receiver
// FSM encoding and the baud divisor helper.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t ST_IDLE   = 3'd0;
  localparam rx_state_t ST_START  = 3'd1;
  localparam rx_state_t ST_DATA   = 3'd2;
  localparam rx_state_t ST_PARITY = 3'd3;
  localparam rx_state_t ST_STOP   = 3'd4;

  function automatic int unsigned baud_cnt(input int unsigned clk, input int unsigned baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Receive-side holding-register handshake between the UART receiver (master)
// and its consumer (slave).
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  parity_err,
    input  frame_err,
    input  overrun,
    output rx_ready
  );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs, with a configurable
// value loaded by the synchronous active-high reset.
module sync_2ff #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 3-sample mid-bit majority vote, start-bit glitch
// rejection, optional parity, 1 or 2 stop bits, valid/ready holding register.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = PAR_NONE,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            rx,
  output logic            busy,
  uart_rx_param_if.master rx_if
);

  localparam int unsigned BAUD_CNT = baud_cnt(CLK_FREQ, BAUD);
  localparam int unsigned HALF     = BAUD_CNT / 2;
  localparam int unsigned CW       = $clog2(BAUD_CNT);
  localparam int unsigned BW       = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
  localparam logic [CW-1:0] CNT_S2   = CW'(HALF + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT - 1);

  logic                 rx_s;
  logic                 rx_prev_d, rx_prev_q;
  rx_state_t            state_d, state_q;
  logic [CW-1:0]        cnt_d, cnt_q;
  logic [BW-1:0]        bidx_d, bidx_q;
  logic [1:0]           samp_d, samp_q;
  logic [DATA_BITS-1:0] shreg_d, shreg_q;
  logic                 perr_d, perr_q;
  logic                 ferr_d, ferr_q;
  logic [DATA_BITS-1:0] data_d, data_q;
  logic                 valid_d, valid_q;
  logic                 perr_out_d, perr_out_q;
  logic                 ferr_out_d, ferr_out_q;
  logic                 overrun_d, overrun_q;

  logic fall, decide, at_wrap, bit_val, commit, accept;

  sync_2ff #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_sync_rx (
    .clk_i(sys_clk),
    .rst_i(sys_rst),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  assign fall    = rx_prev_q & ~rx_s;
  assign decide  = (cnt_q == CNT_S2);
  assign at_wrap = (cnt_q == CNT_LAST);
  // Third sample is the live line value at the decision cycle.
  assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign accept  = valid_q & rx_if.rx_ready;

  always_comb begin
    rx_prev_d = rx_s;
    state_d   = state_q;
    cnt_d     = cnt_q;
    bidx_d    = bidx_q;
    samp_d    = samp_q;
    shreg_d   = shreg_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    commit    = 1'b0;

    if (state_q != ST_IDLE) begin
      cnt_d = at_wrap ? '0 : cnt_q + CW'(1);
      if (cnt_q == CNT_S0) samp_d[0] = rx_s;
      if (cnt_q == CNT_S1) samp_d[1] = rx_s;
    end

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_START;
          cnt_d   = '0;
          bidx_d  = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      ST_START: begin
        if (decide && bit_val) begin
          state_d = ST_IDLE;
        end else if (at_wrap) begin
          state_d = ST_DATA;
          bidx_d  = '0;
        end
      end
      ST_DATA: begin
        if (decide) begin
          shreg_d = {bit_val, shreg_q[DATA_BITS-1:1]};
          bidx_d  = bidx_q + BW'(1);
        end
        if (at_wrap && bidx_q == BW'(DATA_BITS)) begin
          state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          bidx_d  = '0;
        end
      end
      ST_PARITY: begin
        if (decide) begin
          perr_d = (PARITY == PAR_ODD) ? ~(^shreg_q ^ bit_val) : (^shreg_q ^ bit_val);
        end
        if (at_wrap) begin
          state_d = ST_STOP;
          bidx_d  = '0;
        end
      end
      ST_STOP: begin
        if (decide) begin
          if (!bit_val) ferr_d = 1'b1;
          // Commit at the final stop decision so back-to-back frames are caught.
          if (bidx_q == BW'(STOP_BITS - 1)) begin
            commit  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            bidx_d = bidx_q + BW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    overrun_d  = 1'b0;

    if (commit) begin
      if (!valid_q || accept) begin
        data_d     = shreg_q;
        perr_out_d = perr_q;
        ferr_out_d = ferr_q | ~bit_val;
        valid_d    = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_prev_q  <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bidx_q     <= '0;
      samp_q     <= 2'b11;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_prev_q  <= rx_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bidx_q     <= bidx_d;
      samp_q     <= samp_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      overrun_q  <= overrun_d;
    end
  end

  assign busy             = (state_q != ST_IDLE);
  assign rx_if.rx_data    = data_q;
  assign rx_if.rx_valid   = valid_q;
  assign rx_if.parity_err = perr_out_q;
  assign rx_if.frame_err  = ferr_out_q;
  assign rx_if.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1, 8E1, 6O2) with short bit
// times, a frame-level reference model, directed vectors and random frames.
module tb_uart_rx_param;

  localparam int NOBS = 256;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } frm_t;

  typedef struct {
    int         w;
    logic [8:0] data;
    logic       pbit;
    logic [1:0] st;
    logic [8:0] e_data;
    logic       e_perr;
    logic       e_ferr;
  } vec_t;

  logic clk     = 1'b0;
  logic sys_rst = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;
  logic busy_a, busy_b, busy_c;

  uart_rx_param_if #(.DATA_BITS(8)) if_a ();
  uart_rx_param_if #(.DATA_BITS(8)) if_b ();
  uart_rx_param_if #(.DATA_BITS(6)) if_c ();

  assign if_a.rx_ready = ready_a;
  assign if_b.rx_ready = ready_b;
  assign if_c.rx_ready = ready_c;

  uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1)) u_dut_a (
    .sys_clk(clk), .sys_rst(sys_rst), .rx(rx_a), .busy(busy_a), .rx_if(if_a));
  uart_rx_param #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1)) u_dut_b (
    .sys_clk(clk), .sys_rst(sys_rst), .rx(rx_b), .busy(busy_b), .rx_if(if_b));
  uart_rx_param #(.CLK_FREQ(2_000_000), .BAUD(100_000), .DATA_BITS(6), .PARITY(1),
                  .STOP_BITS(2)) u_dut_c (
    .sys_clk(clk), .sys_rst(sys_rst), .rx(rx_c), .busy(busy_c), .rx_if(if_c));

  always #5 clk = ~clk;

  // Observations, written only by the monitor.
  frm_t obs[3][NOBS];
  int   n_obs[3];
  int   valid_hi[3];
  int   ovr_cnt[3];

  // Expectations, written only by the stimulus process.
  frm_t expv[3][NOBS];
  int   n_exp[3];
  int   rd[3];
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vt[10];

  always @(negedge clk) begin
    if (!sys_rst) begin
      if (if_a.rx_valid) valid_hi[0] <= valid_hi[0] + 1;
      if (if_b.rx_valid) valid_hi[1] <= valid_hi[1] + 1;
      if (if_c.rx_valid) valid_hi[2] <= valid_hi[2] + 1;
      if (if_a.overrun) ovr_cnt[0] <= ovr_cnt[0] + 1;
      if (if_b.overrun) ovr_cnt[1] <= ovr_cnt[1] + 1;
      if (if_c.overrun) ovr_cnt[2] <= ovr_cnt[2] + 1;
      if (if_a.rx_valid && if_a.rx_ready && n_obs[0] < NOBS) begin
        obs[0][n_obs[0]] <= {1'b0, if_a.rx_data, if_a.parity_err, if_a.frame_err};
        n_obs[0] <= n_obs[0] + 1;
      end
      if (if_b.rx_valid && if_b.rx_ready && n_obs[1] < NOBS) begin
        obs[1][n_obs[1]] <= {1'b0, if_b.rx_data, if_b.parity_err, if_b.frame_err};
        n_obs[1] <= n_obs[1] + 1;
      end
      if (if_c.rx_valid && if_c.rx_ready && n_obs[2] < NOBS) begin
        obs[2][n_obs[2]] <= {3'b000, if_c.rx_data, if_c.parity_err, if_c.frame_err};
        n_obs[2] <= n_obs[2] + 1;
      end
    end
  end

  function automatic int nbits_of(input int w);
    return (w == 2) ? 6 : 8;
  endfunction
  function automatic int par_of(input int w);
    return (w == 0) ? 0 : ((w == 1) ? 2 : 1);
  endfunction
  function automatic int nstop_of(input int w);
    return (w == 2) ? 2 : 1;
  endfunction
  function automatic int bcnt_of(input int w);
    return (w == 2) ? 20 : 16;
  endfunction

  // Frame-level reference: payload truncated to width, parity by counting ones,
  // framing error if any transmitted stop bit is 0.
  function automatic frm_t model(input int w, input logic [8:0] d, input logic pbit,
                                 input logic [1:0] st);
    frm_t r;
    int   ones;
    ones   = 0;
    r.data = '0;
    for (int i = 0; i < nbits_of(w); i++) begin
      r.data[i] = d[i];
      if (d[i]) ones++;
    end
    if (pbit) ones++;
    case (par_of(w))
      1:       r.perr = (ones % 2) == 0;
      2:       r.perr = (ones % 2) == 1;
      default: r.perr = 1'b0;
    endcase
    r.ferr = 1'b0;
    for (int s = 0; s < nstop_of(w); s++) if (!st[s]) r.ferr = 1'b1;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic put(input int w, input logic v);
    case (w)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic send(input int w, input logic [8:0] d, input logic pbit,
                      input logic [1:0] st);
    int bc;
    bc = bcnt_of(w);
    put(w, 1'b0);
    tick(bc);
    for (int i = 0; i < nbits_of(w); i++) begin
      put(w, d[i]);
      tick(bc);
    end
    if (par_of(w) != 0) begin
      put(w, pbit);
      tick(bc);
    end
    for (int s = 0; s < nstop_of(w); s++) begin
      put(w, st[s]);
      tick(bc);
    end
    put(w, 1'b1);
  endtask

  task automatic push(input int w, input frm_t e);
    expv[w][n_exp[w]] = e;
    n_exp[w]++;
  endtask

  task automatic drain(input int w);
    tick(6);
    while (rd[w] < n_obs[w]) begin
      if (rd[w] >= n_exp[w]) begin
        check("unexpected_commit", 32'(obs[w][rd[w]].data), 32'hFFFF_FFFF);
      end else begin
        check("rx_data", 32'(obs[w][rd[w]].data), 32'(expv[w][rd[w]].data));
        check("parity_err", 32'(obs[w][rd[w]].perr), 32'(expv[w][rd[w]].perr));
        check("frame_err", 32'(obs[w][rd[w]].ferr), 32'(expv[w][rd[w]].ferr));
      end
      rd[w]++;
    end
    check("commit_count", 32'(n_obs[w]), 32'(n_exp[w]));
  endtask

  initial begin
    frm_t       e;
    logic [8:0] d;
    logic       pbit;
    logic [1:0] st;
    int         base_obs, base_hi, base_ovr, bc, gap;

    tick(5);
    sys_rst = 1'b0;
    check("reset_valid_a", 32'(if_a.rx_valid), 32'd0);
    check("reset_data_a", 32'(if_a.rx_data), 32'd0);
    check("reset_perr_a", 32'(if_a.parity_err), 32'd0);
    check("reset_ferr_a", 32'(if_a.frame_err), 32'd0);
    check("reset_overrun_a", 32'(if_a.overrun), 32'd0);
    check("reset_busy_a", 32'(busy_a), 32'd0);
    check("reset_valid_b", 32'(if_b.rx_valid), 32'd0);
    check("reset_busy_c", 32'(busy_c), 32'd0);
    tick(4);

    // Single frame: valid high for exactly one cycle with ready held high.
    base_hi = valid_hi[0];
    push(0, '{data: 9'h055, perr: 1'b0, ferr: 1'b0});
    send(0, 9'h055, 1'b0, 2'b11);
    tick(16);
    drain(0);
    check("valid_one_cycle", 32'(valid_hi[0] - base_hi), 32'd1);

    vt[0] = '{0, 9'h055, 1'b0, 2'b01, 9'h055, 1'b0, 1'b0};
    vt[1] = '{0, 9'h03C, 1'b0, 2'b00, 9'h03C, 1'b0, 1'b1};
    vt[2] = '{1, 9'h0A5, 1'b1, 2'b01, 9'h0A5, 1'b1, 1'b0};
    vt[3] = '{1, 9'h0A5, 1'b0, 2'b01, 9'h0A5, 1'b0, 1'b0};
    vt[4] = '{2, 9'h02D, 1'b1, 2'b11, 9'h02D, 1'b0, 1'b0};
    vt[5] = '{2, 9'h02D, 1'b0, 2'b11, 9'h02D, 1'b1, 1'b0};
    vt[6] = '{2, 9'h015, 1'b0, 2'b01, 9'h015, 1'b0, 1'b1};
    vt[7] = '{2, 9'h03F, 1'b1, 2'b10, 9'h03F, 1'b0, 1'b1};
    vt[8] = '{0, 9'h0FF, 1'b0, 2'b01, 9'h0FF, 1'b0, 1'b0};
    vt[9] = '{0, 9'h000, 1'b0, 2'b01, 9'h000, 1'b0, 1'b0};
    foreach (vt[i]) begin
      push(vt[i].w, '{data: vt[i].e_data, perr: vt[i].e_perr, ferr: vt[i].e_ferr});
      send(vt[i].w, vt[i].data, vt[i].pbit, vt[i].st);
      tick(bcnt_of(vt[i].w));
      drain(vt[i].w);
    end

    // Back-to-back frames with no idle gap.
    base_hi  = valid_hi[0];
    base_ovr = ovr_cnt[0];
    for (int k = 0; k < 8; k++) begin
      push(0, '{data: 9'(k), perr: 1'b0, ferr: 1'b0});
      send(0, 9'(k), 1'b0, 2'b11);
    end
    tick(16);
    drain(0);
    check("b2b_valid_cycles", 32'(valid_hi[0] - base_hi), 32'd8);
    check("b2b_no_overrun", 32'(ovr_cnt[0] - base_ovr), 32'd0);

    // Short low glitch in IDLE is rejected at the start-bit vote.
    base_obs = n_obs[0];
    rx_a = 1'b0;
    tick(4);
    check("glitch_busy_rises", 32'(busy_a), 32'd1);
    rx_a = 1'b1;
    tick(20);
    check("glitch_busy_falls", 32'(busy_a), 32'd0);
    check("glitch_no_commit", 32'(n_obs[0] - base_obs), 32'd0);

    // Overrun: second frame dropped while the first is held.
    ready_a  = 1'b0;
    base_ovr = ovr_cnt[0];
    send(0, 9'h011, 1'b0, 2'b01);
    tick(16);
    check("ovr_first_valid", 32'(if_a.rx_valid), 32'd1);
    check("ovr_first_data", 32'(if_a.rx_data), 32'h11);
    send(0, 9'h022, 1'b0, 2'b01);
    tick(4);
    check("ovr_pulse_count", 32'(ovr_cnt[0] - base_ovr), 32'd1);
    check("ovr_data_kept", 32'(if_a.rx_data), 32'h11);
    check("ovr_valid_kept", 32'(if_a.rx_valid), 32'd1);
    push(0, '{data: 9'h011, perr: 1'b0, ferr: 1'b0});
    ready_a = 1'b1;
    tick(1);
    check("ovr_valid_falls", 32'(if_a.rx_valid), 32'd0);
    drain(0);

    // Reset pulse in the middle of data bit 4 of 0xF0.
    base_obs = n_obs[0];
    bc = bcnt_of(0);
    put(0, 1'b0);
    tick(bc * 5);
    put(0, 1'b1);
    tick(bc / 2);
    sys_rst = 1'b1;
    tick(1);
    sys_rst = 1'b0;
    check("rst_mid_busy", 32'(busy_a), 32'd0);
    tick(bc * 5);
    check("rst_mid_no_commit", 32'(n_obs[0] - base_obs), 32'd0);
    push(0, '{data: 9'h00F, perr: 1'b0, ferr: 1'b0});
    send(0, 9'h00F, 1'b0, 2'b01);
    tick(bc);
    drain(0);

    // Random frames on each configuration, random gaps including none.
    for (int w = 0; w < 3; w++) begin
      bc = bcnt_of(w);
      for (int k = 0; k < 15; k++) begin
        d     = 9'($urandom);
        pbit  = 1'($urandom_range(0, 1));
        st[0] = ($urandom_range(0, 7) != 0);
        st[1] = ($urandom_range(0, 7) != 0);
        e     = model(w, d, pbit, st);
        push(w, e);
        send(w, d, pbit, st);
        if (!st[nstop_of(w) - 1]) tick(bc);
        gap = $urandom_range(0, bc);
        if (gap > 0) tick(gap);
      end
      tick(bc);
      drain(w);
    end
    check("no_overrun_b", 32'(ovr_cnt[1]), 32'd0);
    check("no_overrun_c", 32'(ovr_cnt[2]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
